// File: rtl/pht_if.sv
// Prediction/training bus of the pattern history table.
// Master side (fetch + reorder buffer) drives indices and training; slave side (table) returns predictions.
interface pht_if #(
  parameter int unsigned PHT_ADDRESS = 9,
  parameter int unsigned NUM_READ    = 2
);
  logic [NUM_READ*PHT_ADDRESS-1:0] pht_index;
  logic                            update_pht;
  logic [PHT_ADDRESS-1:0]          rb_pht_index;
  logic                            actual_taken;
  logic [NUM_READ-1:0]             pred_taken;
  logic [NUM_READ-1:0]             pred_strong;
  logic                            pht_ready;

  modport master (
    output pht_index, update_pht, rb_pht_index, actual_taken,
    input  pred_taken, pred_strong, pht_ready
  );

  modport slave (
    input  pht_index, update_pht, rb_pht_index, actual_taken,
    output pred_taken, pred_strong, pht_ready
  );
endinterface

// File: rtl/pht_multiport_init.sv
// Multi-port pattern history table with a post-reset init sweep, ready flag and confidence outputs.
// Optional macro PHT_BYPASS_EN: write-first forwarding of a same-cycle training result to read ports.
module pht_multiport_init #(
  parameter int unsigned PHT_ADDRESS  = 9,
  parameter int unsigned COUNTER_SIZE = 2,
  parameter int unsigned NUM_READ     = 2,
  parameter int unsigned INIT_VALUE   = 1
) (
  input  logic CLK,
  input  logic reset,
  pht_if.slave bus
);
  localparam int unsigned              DEPTH     = 1 << PHT_ADDRESS;
  localparam logic [COUNTER_SIZE-1:0]  CNT_MAX   = '1;
  localparam logic [COUNTER_SIZE-1:0]  CNT_ZERO  = '0;
  localparam logic [COUNTER_SIZE-1:0]  CNT_INIT  = COUNTER_SIZE'(INIT_VALUE);
  localparam logic [PHT_ADDRESS-1:0]   LAST_IDX  = PHT_ADDRESS'(DEPTH - 1);
  localparam string                    RAM_STYLE = (NUM_READ <= 2) ? "block" : "distributed";

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  r_state;
  logic [PHT_ADDRESS-1:0]  r_init_ptr;
  logic [NUM_READ-1:0]     r_pred_taken;
  logic [NUM_READ-1:0]     r_pred_strong;
  logic                    r_ready;

  (* ram_style = RAM_STYLE *)
  logic [COUNTER_SIZE-1:0] r_pht [DEPTH];

  logic [COUNTER_SIZE-1:0] w_cur;
  logic [COUNTER_SIZE-1:0] w_trained;
  logic                    w_train;
  logic                    w_init_wr;
  logic [PHT_ADDRESS-1:0]  w_idx [NUM_READ];
  logic [COUNTER_SIZE-1:0] w_rd  [NUM_READ];

  // Saturating train value for the retiring branch's entry.
  always_comb begin
    w_cur     = r_pht[bus.rb_pht_index];
    w_trained = w_cur;
    if (bus.actual_taken) begin
      if (w_cur != CNT_MAX) w_trained = w_cur + COUNTER_SIZE'(1);
    end else begin
      if (w_cur != CNT_ZERO) w_trained = w_cur - COUNTER_SIZE'(1);
    end
  end

  assign w_train   = (r_state == ST_RUN) && bus.update_pht && !reset;
  assign w_init_wr = (r_state == ST_INIT) && !reset;

  // Per-port read values, optionally forwarding the same-cycle training result.
  always_comb begin
    for (int i = 0; i < int'(NUM_READ); i++) begin
      w_idx[i] = bus.pht_index[i*PHT_ADDRESS +: PHT_ADDRESS];
      w_rd[i]  = r_pht[w_idx[i]];
`ifdef PHT_BYPASS_EN
      if (w_train && (w_idx[i] == bus.rb_pht_index)) w_rd[i] = w_trained;
`else
      w_rd[i]  = r_pht[w_idx[i]];
`endif
    end
  end

  // Table storage: init sweep has priority, then training; contents are never reset.
  always_ff @(posedge CLK) begin
    if (w_init_wr) begin
      r_pht[r_init_ptr] <= CNT_INIT;
    end else if (w_train) begin
      r_pht[bus.rb_pht_index] <= w_trained;
    end
  end

  // Sweep/run control with registered prediction outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= ST_INIT;
      r_init_ptr    <= '0;
      r_pred_taken  <= '0;
      r_pred_strong <= '0;
      r_ready       <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_ptr    <= r_init_ptr + PHT_ADDRESS'(1);
          r_pred_taken  <= '0;
          r_pred_strong <= '0;
          if (r_init_ptr == LAST_IDX) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < int'(NUM_READ); i++) begin
            r_pred_taken[i]  <= w_rd[i][COUNTER_SIZE-1];
            r_pred_strong[i] <= (w_rd[i] == CNT_ZERO) || (w_rd[i] == CNT_MAX);
          end
        end
        default: begin
          r_state    <= ST_INIT;
          r_init_ptr <= '0;
          r_ready    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_strong = r_pred_strong;
  assign bus.pht_ready   = r_ready;
endmodule

// File: tb/tb_pht_multiport_init.sv
// Self-checking bench for pht_multiport_init: directed scenarios plus randomized traffic
// against an array-based counter model.
module tb_pht_multiport_init;
  localparam int unsigned A     = 9;
  localparam int unsigned CS    = 2;
  localparam int unsigned NR    = 2;
  localparam int unsigned INITV = 1;
  localparam int unsigned DEPTH = 1 << A;
  localparam int unsigned MAXV  = (1 << CS) - 1;
  localparam int unsigned HALF  = 1 << (CS - 1);
`ifdef PHT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int unsigned model [DEPTH];

  pht_if #(.PHT_ADDRESS(A), .NUM_READ(NR)) bus ();

  pht_multiport_init #(
    .PHT_ADDRESS(A), .COUNTER_SIZE(CS), .NUM_READ(NR), .INIT_VALUE(INITV)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int unsigned i0, input int unsigned i1, input bit upd,
                       input int unsigned rb, input bit tk);
    bus.pht_index    = {A'(i1), A'(i0)};
    bus.update_pht   = upd;
    bus.rb_pht_index = A'(rb);
    bus.actual_taken = tk;
  endtask

  function automatic int unsigned sat_step(input int unsigned v, input bit tk);
    if (tk) return (v >= MAXV) ? MAXV : v + 1;
    return (v == 0) ? 0 : v - 1;
  endfunction

  // Value a read port should report given the current drive and the model before the edge.
  function automatic int unsigned port_value(input int unsigned idx, input bit upd,
                                             input int unsigned rb, input bit tk);
    if (BYPASS && upd && idx == rb) return sat_step(model[rb], tk);
    return model[idx];
  endfunction

  task automatic model_init();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = INITV;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 1'b0, 0, 1'b0);
    tick();
    tick();
    n_tests++;
    if (bus.pht_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=0", bus.pht_ready);
    end
    n_tests++;
    if (bus.pred_taken !== 2'b00) begin
      n_fail++; $display("FAIL reset_taken got=%b exp=00", bus.pred_taken);
    end
    n_tests++;
    if (bus.pred_strong !== 2'b00) begin
      n_fail++; $display("FAIL reset_strong got=%b exp=00", bus.pred_strong);
    end
    reset = 1'b0;
    // Training attempts on idx 3 throughout the sweep must be ignored.
    for (int c = 1; c <= int'(DEPTH); c++) begin
      drive($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 1'b1, 3, c[0]);
      tick();
      n_tests++;
      if (bus.pht_ready !== (c == int'(DEPTH))) begin
        n_fail++; $display("FAIL sweep_ready cycle=%0d got=%b exp=%b", c, bus.pht_ready, c == int'(DEPTH));
      end
      n_tests++;
      if ({bus.pred_strong, bus.pred_taken} !== 4'b0000) begin
        n_fail++; $display("FAIL sweep_preds cycle=%0d got=%b exp=0000", c, {bus.pred_strong, bus.pred_taken});
      end
    end
    model_init();
    drive(3, 3, 1'b0, 0, 1'b0);
    tick();
    n_tests++;
    if ({bus.pred_strong, bus.pred_taken} !== 4'b0000) begin
      n_fail++; $display("FAIL init_ignore_idx3 got=%b exp=0000", {bus.pred_strong, bus.pred_taken});
    end
  endtask

  task automatic test_train_taken();
    for (int k = 1; k <= 4; k++) begin
      drive(5, 5, 1'b1, 5, 1'b1);
      model[5] = sat_step(model[5], 1'b1);
      tick();
      drive(5, 9, 1'b0, 0, 1'b0);
      tick();
      n_tests++;
      if (bus.pred_taken[0] !== 1'b1 || bus.pred_strong[0] !== (k >= 2)) begin
        n_fail++; $display("FAIL train_taken k=%0d got taken=%b strong=%b exp taken=1 strong=%b",
                           k, bus.pred_taken[0], bus.pred_strong[0], k >= 2);
      end
    end
  endtask

  task automatic test_train_not_taken();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 5, 1'b1, 5, 1'b0);
      model[5] = sat_step(model[5], 1'b0);
      tick();
      drive(9, 5, 1'b0, 0, 1'b0);
      tick();
      n_tests++;
      if (bus.pred_taken[1] !== (k == 1) || bus.pred_strong[1] !== (k >= 3)) begin
        n_fail++; $display("FAIL train_not_taken k=%0d got taken=%b strong=%b exp taken=%b strong=%b",
                           k, bus.pred_taken[1], bus.pred_strong[1], k == 1, k >= 3);
      end
    end
  endtask

  task automatic test_same_index();
    logic [1:0] exp_t;
    exp_t = BYPASS ? 2'b11 : 2'b00;
    drive(7, 7, 1'b1, 7, 1'b1);
    model[7] = sat_step(model[7], 1'b1);
    tick();
    n_tests++;
    if (bus.pred_taken !== exp_t || bus.pred_strong !== 2'b00) begin
      n_fail++; $display("FAIL same_idx_train got taken=%b strong=%b exp taken=%b strong=00",
                         bus.pred_taken, bus.pred_strong, exp_t);
    end
    drive(7, 7, 1'b0, 0, 1'b0);
    tick();
    n_tests++;
    if (bus.pred_taken !== 2'b11 || bus.pred_strong !== 2'b00) begin
      n_fail++; $display("FAIL same_idx_next got taken=%b strong=%b exp taken=11 strong=00",
                         bus.pred_taken, bus.pred_strong);
    end
  endtask

  // Dense random traffic over a small index window so trains and reads collide often.
  task automatic test_back_to_back();
    int unsigned i0, i1, rb, e0, e1;
    bit upd, tk;
    logic [3:0] exp_v;
    for (int n = 0; n < 600; n++) begin
      i0  = $urandom_range(16, 27);
      i1  = ($urandom_range(0, 3) == 0) ? i0 : $urandom_range(16, 27);
      rb  = ($urandom_range(0, 2) == 0) ? i0 : $urandom_range(16, 27);
      upd = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      drive(i0, i1, upd, rb, tk);
      e0 = port_value(i0, upd, rb, tk);
      e1 = port_value(i1, upd, rb, tk);
      if (upd) model[rb] = sat_step(model[rb], tk);
      exp_v = {(e1 == 0 || e1 == MAXV), (e0 == 0 || e0 == MAXV), e1 >= HALF, e0 >= HALF};
      tick();
      n_tests++;
      if ({bus.pred_strong, bus.pred_taken} !== exp_v) begin
        n_fail++; $display("FAIL random n=%0d idx=%0d/%0d got=%b exp=%b",
                           n, i0, i1, {bus.pred_strong, bus.pred_taken}, exp_v);
      end
    end
  endtask

  task automatic test_reset_restart();
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 1'b1, 20, 1'b1);
      tick();
    end
    drive(20, 20, 1'b0, 0, 1'b0);
    tick();
    n_tests++;
    if (bus.pred_taken !== 2'b11) begin
      n_fail++; $display("FAIL pre_restart_taken got=%b exp=11", bus.pred_taken);
    end
    // Two passes: reset while in RUN, then reset again at sweep cycle 200.
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b1;
      tick();
      n_tests++;
      if (bus.pht_ready !== 1'b0) begin
        n_fail++; $display("FAIL restart_ready_drop pass=%0d got=%b exp=0", pass, bus.pht_ready);
      end
      reset = 1'b0;
      if (pass == 0) begin
        for (int c = 1; c <= 200; c++) begin
          drive($urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 20, 1'b1);
          tick();
        end
      end
    end
    for (int c = 1; c <= int'(DEPTH); c++) begin
      drive($urandom_range(0, 31), $urandom_range(0, 31), 1'b1, 5, 1'b1);
      tick();
      n_tests++;
      if (bus.pht_ready !== (c == int'(DEPTH)) || {bus.pred_strong, bus.pred_taken} !== 4'b0000) begin
        n_fail++; $display("FAIL restart_sweep cycle=%0d got ready=%b preds=%b", c, bus.pht_ready,
                           {bus.pred_strong, bus.pred_taken});
      end
    end
    model_init();
    drive(20, 5, 1'b0, 0, 1'b0);
    tick();
    n_tests++;
    if ({bus.pred_strong, bus.pred_taken} !== 4'b0000) begin
      n_fail++; $display("FAIL restart_contents idx20/5 got=%b exp=0000", {bus.pred_strong, bus.pred_taken});
    end
    drive(7, 17, 1'b0, 0, 1'b0);
    tick();
    n_tests++;
    if ({bus.pred_strong, bus.pred_taken} !== 4'b0000) begin
      n_fail++; $display("FAIL restart_contents idx7/17 got=%b exp=0000", {bus.pred_strong, bus.pred_taken});
    end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_same_index();
    test_back_to_back();
    test_reset_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
